// File: rtl/tdm_frame_sched.sv
// TDM frame scheduler: two requester channels feed 2-deep FIFOs that are
// drained into a pair of frame words once every G_FRAME_MCLKS cycles.
module tdm_frame_sched #(
    parameter int G_BITS        = 16,
    parameter int G_FRAME_MCLKS = 66
) (
    input  logic              in_mclk,
    input  logic              in_rst_n,
    input  logic              in_enable,
    input  logic [G_BITS-1:0] in_ch1_data,
    input  logic [G_BITS-1:0] in_ch2_data,
    input  logic              in_ch1_valid,
    input  logic              in_ch2_valid,
    output logic              out_ch1_ready,
    output logic              out_ch2_ready,
    output logic [G_BITS-1:0] out_frame_1,
    output logic [G_BITS-1:0] out_frame_2,
    output logic              out_frame_strobe,
    output logic              out_running,
    output logic [7:0]        out_underrun_cnt_1,
    output logic [7:0]        out_underrun_cnt_2,
    output logic [1:0]        out_dbg_state
);

    // Handshake: a sample transfers at a rising edge where valid and ready are
    // both high; ready never looks at valid, and a full FIFO refuses a push
    // even when the same edge pops it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [15:0] FRAME_LAST = 16'(G_FRAME_MCLKS - 1);

    state_t            state;
    state_t            state_nx;
    logic [15:0]       frame_cnt;
    logic              frame_edge;
    logic              strobe_q;
    logic              running_q;

    logic [G_BITS-1:0] fifo_head [2];
    logic [G_BITS-1:0] fifo_tail [2];
    logic [1:0]        fifo_cnt  [2];
    logic [G_BITS-1:0] frame_q   [2];
    logic [7:0]        urun_cnt  [2];
    logic [G_BITS-1:0] ch_data   [2];
    logic [1:0]        ch_valid;
    logic [1:0]        ch_ready;
    logic [1:0]        push;
    logic [1:0]        pop;

    assign ch_data[0] = in_ch1_data;
    assign ch_data[1] = in_ch2_data;
    assign ch_valid   = {in_ch2_valid, in_ch1_valid};

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (in_enable) state_nx = ST_PRIME;
            ST_PRIME: begin
                if (!in_enable)
                    state_nx = ST_IDLE;
                else if (fifo_cnt[0] != 2'd0 && fifo_cnt[1] != 2'd0)
                    state_nx = ST_RUN;
            end
            ST_RUN:   if (!in_enable) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // A dropped enable suppresses the frame edge so nothing pops or strobes.
    assign frame_edge = (state == ST_RUN) && in_enable && (frame_cnt == 16'd0);

    always_comb begin
        ch_ready = 2'b00;
        push     = 2'b00;
        pop      = 2'b00;
        for (int c = 0; c < 2; c++) begin
            ch_ready[c] = (state != ST_IDLE) && (fifo_cnt[c] != 2'd2);
            push[c]     = ch_valid[c] && ch_ready[c];
            pop[c]      = frame_edge && (fifo_cnt[c] != 2'd0);
        end
    end

    always_ff @(posedge in_mclk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state     <= ST_IDLE;
            running_q <= 1'b0;
            strobe_q  <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            state     <= state_nx;
            running_q <= (state_nx == ST_RUN);
            strobe_q  <= frame_edge;
            if (state == ST_RUN && state_nx == ST_RUN)
                frame_cnt <= (frame_cnt == FRAME_LAST) ? 16'd0 : frame_cnt + 16'd1;
            else
                frame_cnt <= 16'd0;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_ch
        always_ff @(posedge in_mclk or negedge in_rst_n) begin
            if (!in_rst_n) begin
                fifo_head[g] <= '0;
                fifo_tail[g] <= '0;
                fifo_cnt[g]  <= 2'd0;
                frame_q[g]   <= '0;
                urun_cnt[g]  <= 8'd0;
            end else begin
                if (frame_edge) begin
                    if (fifo_cnt[g] != 2'd0)
                        frame_q[g] <= fifo_head[g];
                    else if (urun_cnt[g] != 8'hFF)
                        urun_cnt[g] <= urun_cnt[g] + 8'd1;
                end
                // Leaving for IDLE flushes, which also drops a same-edge push.
                if (state_nx == ST_IDLE) begin
                    fifo_cnt[g] <= 2'd0;
                end else begin
                    case ({push[g], pop[g]})
                        2'b10: begin
                            if (fifo_cnt[g] == 2'd0)
                                fifo_head[g] <= ch_data[g];
                            else
                                fifo_tail[g] <= ch_data[g];
                            fifo_cnt[g] <= fifo_cnt[g] + 2'd1;
                        end
                        2'b01: begin
                            fifo_head[g] <= fifo_tail[g];
                            fifo_cnt[g]  <= fifo_cnt[g] - 2'd1;
                        end
                        // Push with pop only happens at one entry: the new word becomes head.
                        2'b11:   fifo_head[g] <= ch_data[g];
                        default: ;
                    endcase
                end
            end
        end
    end

    assign out_ch1_ready      = ch_ready[0];
    assign out_ch2_ready      = ch_ready[1];
    assign out_frame_1        = frame_q[0];
    assign out_frame_2        = frame_q[1];
    assign out_frame_strobe   = strobe_q;
    assign out_running        = running_q;
    assign out_underrun_cnt_1 = urun_cnt[0];
    assign out_underrun_cnt_2 = urun_cnt[1];
    assign out_dbg_state      = state;

endmodule

// File: tb/tb_tdm_frame_sched.sv
// Bench for tdm_frame_sched: queue-based frame model plus directed and random
// scenarios for startup, steady stream, underrun, backpressure, saturation, abort.
module tb_tdm_frame_sched;

    localparam int W = 16;
    localparam int F = 66;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] ch1_data = '0;
    logic [W-1:0] ch2_data = '0;
    logic         ch1_valid = 1'b0;
    logic         ch2_valid = 1'b0;
    logic         ready1, ready2;
    logic [W-1:0] frame1, frame2;
    logic         strobe, running;
    logic [7:0]   ucnt1, ucnt2;
    logic [1:0]   dbg_state;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_strobe_cyc = 0;
    int bench_u1 = 0;
    int bench_u2 = 0;
    logic [W-1:0] sb_f1 = '0;
    logic [W-1:0] sb_f2 = '0;
    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q2[$];

    tdm_frame_sched #(.G_BITS(W), .G_FRAME_MCLKS(F)) dut (
        .in_mclk(clk), .in_rst_n(rst_n), .in_enable(enable),
        .in_ch1_data(ch1_data), .in_ch2_data(ch2_data),
        .in_ch1_valid(ch1_valid), .in_ch2_valid(ch2_valid),
        .out_ch1_ready(ready1), .out_ch2_ready(ready2),
        .out_frame_1(frame1), .out_frame_2(frame2),
        .out_frame_strobe(strobe), .out_running(running),
        .out_underrun_cnt_1(ucnt1), .out_underrun_cnt_2(ucnt2),
        .out_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // m_mode: 0 idle, 1 priming, 2 running. m_run_t counts edges spent running;
    // a frame falls on every multiple of F. Ready values are for the next edge.
    int           m_mode = 0;
    int           m_run_t = 0;
    logic [W-1:0] m_q1[$];
    logic [W-1:0] m_q2[$];
    logic [W-1:0] m_f1 = '0;
    logic [W-1:0] m_f2 = '0;
    bit           m_strobe = 0;
    bit           m_rdy1 = 0;
    bit           m_rdy2 = 0;
    bit           m_acc1, m_acc2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_run_t = 0; m_q1.delete(); m_q2.delete();
            m_f1 = '0; m_f2 = '0; m_strobe = 0; m_rdy1 = 0; m_rdy2 = 0;
        end else begin
            m_acc1 = ch1_valid && m_rdy1;
            m_acc2 = ch2_valid && m_rdy2;
            m_strobe = 0;
            if (m_mode == 0) begin
                if (enable) m_mode = 1;
            end else if (!enable) begin
                m_mode = 0; m_q1.delete(); m_q2.delete();
            end else begin
                if (m_mode == 2) begin
                    if (m_run_t % F == 0) begin
                        m_strobe = 1;
                        if (m_q1.size() != 0) m_f1 = m_q1.pop_front();
                        if (m_q2.size() != 0) m_f2 = m_q2.pop_front();
                    end
                    m_run_t++;
                end else if (m_q1.size() != 0 && m_q2.size() != 0) begin
                    m_mode = 2; m_run_t = 0;
                end
                if (m_acc1) m_q1.push_back(ch1_data);
                if (m_acc2) m_q2.push_back(ch2_data);
            end
            m_rdy1 = (m_mode != 0) && (m_q1.size() < 2);
            m_rdy2 = (m_mode != 0) && (m_q2.size() < 2);
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; ch1_valid = 1'b0; ch2_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({ready1, ready2, strobe, running} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctrl got=%b exp=0000", {ready1, ready2, strobe, running});
        end
        n_vec++;
        if ({frame1, frame2} !== '0) begin
            n_err++; $display("FAIL reset_frames got=%h/%h exp=0/0", frame1, frame2);
        end
        n_vec++;
        if ({ucnt1, ucnt2} !== 16'h0000) begin
            n_err++; $display("FAIL reset_ucnt got=%0d/%0d exp=0/0", ucnt1, ucnt2);
        end
        n_vec++;
        if (dbg_state !== 2'd0) begin
            n_err++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
    endtask

    // Edge e is the e-th rising edge after reset release.
    task automatic test_startup();
        enable = 1'b1; ch1_valid = 1'b0; ch2_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            ch1_valid = (e == 3);  ch1_data = 16'h1111;
            ch2_valid = (e == 10); ch2_data = 16'h2222;
            @(negedge clk);
            n_vec++;
            if (running !== (e >= 11)) begin
                n_err++; $display("FAIL startup_running edge=%0d got=%b exp=%b", e, running, e >= 11);
            end
            n_vec++;
            if (strobe !== (e == 12) || strobe !== m_strobe) begin
                n_err++; $display("FAIL startup_strobe edge=%0d got=%b exp=%b", e, strobe, e == 12);
            end
            if (e == 2) begin
                n_vec++;
                if ({ready1, ready2} !== 2'b11) begin
                    n_err++; $display("FAIL startup_ready got=%b exp=11", {ready1, ready2});
                end
            end
            if (e == 12) begin
                last_strobe_cyc = cyc;
                n_vec++;
                if (frame1 !== 16'h1111 || frame2 !== 16'h2222) begin
                    n_err++; $display("FAIL startup_frames got=%h/%h exp=1111/2222", frame1, frame2);
                end
            end
        end
        ch1_valid = 1'b0; ch2_valid = 1'b0;
        sb_f1 = 16'h1111; sb_f2 = 16'h2222;
    endtask

    task automatic test_steady();
        int seen = 0;
        int p1 = 30;
        int p2 = 40;
        int phase;
        logic [W-1:0] w1, w2;
        exp_q1.delete(); exp_q2.delete();
        for (int i = 0; i < 9 * F && seen < 8; i++) begin
            phase = m_run_t % F;
            ch1_valid = (phase == p1); ch2_valid = (phase == p2);
            ch1_data = W'($urandom); ch2_data = W'($urandom);
            if (ch1_valid && m_rdy1) exp_q1.push_back(ch1_data);
            if (ch2_valid && m_rdy2) exp_q2.push_back(ch2_data);
            @(negedge clk);
            n_vec++;
            if (strobe !== m_strobe || running !== (m_mode == 2)) begin
                n_err++; $display("FAIL steady_ctrl cyc=%0d got=%b%b exp=%b%b", cyc, strobe, running, m_strobe, m_mode == 2);
            end
            if (strobe) begin
                seen++;
                w1 = (exp_q1.size() != 0) ? exp_q1.pop_front() : sb_f1;
                w2 = (exp_q2.size() != 0) ? exp_q2.pop_front() : sb_f2;
                sb_f1 = w1; sb_f2 = w2;
                n_vec++;
                if (cyc - last_strobe_cyc !== F) begin
                    n_err++; $display("FAIL steady_period got=%0d exp=%0d", cyc - last_strobe_cyc, F);
                end
                last_strobe_cyc = cyc;
                n_vec++;
                if (frame1 !== w1 || frame2 !== w2 || frame1 !== m_f1) begin
                    n_err++; $display("FAIL steady_frames got=%h/%h exp=%h/%h", frame1, frame2, w1, w2);
                end
                n_vec++;
                if ({ucnt1, ucnt2} !== 16'h0000) begin
                    n_err++; $display("FAIL steady_ucnt got=%0d/%0d exp=0/0", ucnt1, ucnt2);
                end
                p1 = $urandom_range(2, 60); p2 = $urandom_range(2, 60);
            end
        end
        ch1_valid = 1'b0; ch2_valid = 1'b0;
        n_vec++;
        if (seen != 8) begin
            n_err++; $display("FAIL steady_count got=%0d exp=8", seen);
        end
    endtask

    task automatic test_underrun();
        int fr = 0;
        int phase;
        for (int i = 0; i < 4 * F && fr < 3; i++) begin
            phase = m_run_t % F;
            ch1_valid = (phase == 20); ch2_valid = (phase == 20) && (fr != 1);
            if (ch1_valid) begin ch1_data = W'($urandom); sb_f1 = ch1_data; end
            if (ch2_valid) begin ch2_data = W'($urandom); sb_f2 = ch2_data; end
            @(negedge clk);
            n_vec++;
            if (strobe !== m_strobe) begin
                n_err++; $display("FAIL underrun_strobe cyc=%0d got=%b exp=%b", cyc, strobe, m_strobe);
            end
            if (strobe) begin
                fr++;
                n_vec++;
                if (frame1 !== sb_f1 || frame2 !== sb_f2) begin
                    n_err++; $display("FAIL underrun_frames fr=%0d got=%h/%h exp=%h/%h", fr, frame1, frame2, sb_f1, sb_f2);
                end
                n_vec++;
                if (ucnt1 !== 8'd0 || ucnt2 !== 8'((fr >= 2) ? 1 : 0)) begin
                    n_err++; $display("FAIL underrun_cnt fr=%0d got=%0d/%0d exp=0/%0d", fr, ucnt1, ucnt2, (fr >= 2) ? 1 : 0);
                end
            end
        end
        ch1_valid = 1'b0; ch2_valid = 1'b0;
        bench_u2 = 1;
        n_vec++;
        if (fr != 3) begin
            n_err++; $display("FAIL underrun_count got=%0d exp=3", fr);
        end
    endtask

    task automatic test_back_to_back();
        int seen = 0;
        bit acc1, acc2;
        enable = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({ready1, ready2, running, strobe} !== 4'b0000 || dbg_state !== 2'd0) begin
            n_err++; $display("FAIL disable_ctrl got=%b st=%0d exp=0000 st=0", {ready1, ready2, running, strobe}, dbg_state);
        end
        n_vec++;
        if (frame1 !== sb_f1 || frame2 !== sb_f2) begin
            n_err++; $display("FAIL disable_retain got=%h/%h exp=%h/%h", frame1, frame2, sb_f1, sb_f2);
        end
        enable = 1'b1;
        exp_q1.delete(); exp_q2.delete();
        ch1_valid = 1'b1; ch2_valid = 1'b1;
        ch1_data = W'($urandom); ch2_data = W'($urandom);
        for (int i = 0; i < 5 * F && seen < 3; i++) begin
            acc1 = m_rdy1; acc2 = m_rdy2;
            if (acc1) exp_q1.push_back(ch1_data);
            if (acc2) exp_q2.push_back(ch2_data);
            @(negedge clk);
            if (strobe) begin
                seen++;
                sb_f1 = (exp_q1.size() != 0) ? exp_q1.pop_front() : sb_f1;
                sb_f2 = (exp_q2.size() != 0) ? exp_q2.pop_front() : sb_f2;
                n_vec++;
                if (frame1 !== sb_f1 || frame2 !== sb_f2) begin
                    n_err++; $display("FAIL bp_frames got=%h/%h exp=%h/%h", frame1, frame2, sb_f1, sb_f2);
                end
            end
            n_vec++;
            if (ready1 !== (exp_q1.size() < 2) || ready2 !== (exp_q2.size() < 2)) begin
                n_err++; $display("FAIL bp_ready cyc=%0d got=%b%b exp=%b%b", cyc, ready1, ready2, exp_q1.size() < 2, exp_q2.size() < 2);
            end
            n_vec++;
            if (strobe !== m_strobe || ucnt2 !== 8'(bench_u2)) begin
                n_err++; $display("FAIL bp_strobe cyc=%0d got=%b/%0d exp=%b/%0d", cyc, strobe, ucnt2, m_strobe, bench_u2);
            end
            if (acc1) ch1_data = W'($urandom);
            if (acc2) ch2_data = W'($urandom);
        end
        ch1_valid = 1'b0; ch2_valid = 1'b0;
        n_vec++;
        if (seen != 3) begin
            n_err++; $display("FAIL bp_count got=%0d exp=3", seen);
        end
    endtask

    task automatic test_saturation();
        int seen = 0;
        int phase;
        bench_u1 = 0;
        for (int i = 0; i < 302 * F && seen < 300; i++) begin
            phase = m_run_t % F;
            ch1_valid = 1'b0;
            ch2_valid = (phase == 20);
            if (ch2_valid) begin
                ch2_data = W'($urandom);
                if (m_rdy2) exp_q2.push_back(ch2_data);
            end
            @(negedge clk);
            n_vec++;
            if (strobe !== m_strobe) begin
                n_err++; $display("FAIL sat_strobe cyc=%0d got=%b exp=%b", cyc, strobe, m_strobe);
            end
            if (strobe) begin
                seen++;
                if (exp_q1.size() != 0) sb_f1 = exp_q1.pop_front();
                else if (bench_u1 < 255) bench_u1++;
                if (exp_q2.size() != 0) sb_f2 = exp_q2.pop_front();
                else if (bench_u2 < 255) bench_u2++;
                n_vec++;
                if (ucnt1 !== 8'(bench_u1) || ucnt2 !== 8'(bench_u2)) begin
                    n_err++; $display("FAIL sat_cnt frame=%0d got=%0d/%0d exp=%0d/%0d", seen, ucnt1, ucnt2, bench_u1, bench_u2);
                end
                n_vec++;
                if (frame1 !== sb_f1 || frame2 !== sb_f2) begin
                    n_err++; $display("FAIL sat_frames got=%h/%h exp=%h/%h", frame1, frame2, sb_f1, sb_f2);
                end
            end
        end
        ch2_valid = 1'b0;
        n_vec++;
        if (ucnt1 !== 8'd255 || seen != 300) begin
            n_err++; $display("FAIL sat_final got=%0d frames=%0d exp=255 frames=300", ucnt1, seen);
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] a1, a2;
        bit got = 0;
        repeat (30) @(negedge clk);
        enable = 1'b0;
        ch1_valid = 1'b1; ch2_valid = 1'b1;
        ch1_data = W'($urandom); ch2_data = W'($urandom);
        @(negedge clk);
        ch1_valid = 1'b0; ch2_valid = 1'b0;
        n_vec++;
        if ({ready1, ready2, running, strobe} !== 4'b0000 || dbg_state !== 2'd0) begin
            n_err++; $display("FAIL abort_ctrl got=%b st=%0d exp=0000 st=0", {ready1, ready2, running, strobe}, dbg_state);
        end
        n_vec++;
        if (frame1 !== sb_f1 || frame2 !== sb_f2) begin
            n_err++; $display("FAIL abort_retain got=%h/%h exp=%h/%h", frame1, frame2, sb_f1, sb_f2);
        end
        for (int i = 0; i < 2 * F; i++) begin
            @(negedge clk);
            n_vec++;
            if (strobe !== 1'b0 || ready1 !== 1'b0) begin
                n_err++; $display("FAIL abort_idle cyc=%0d strobe=%b ready=%b exp=0/0", cyc, strobe, ready1);
            end
        end
        // Restart: the words discarded on the abort edge must not reappear.
        enable = 1'b1;
        @(negedge clk);
        a1 = W'($urandom); a2 = W'($urandom);
        ch1_data = a1; ch2_data = a2; ch1_valid = 1'b1; ch2_valid = 1'b1;
        @(negedge clk);
        ch1_valid = 1'b0; ch2_valid = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            @(negedge clk);
            if (strobe) got = 1;
        end
        n_vec++;
        if (!got || frame1 !== a1 || frame2 !== a2) begin
            n_err++; $display("FAIL abort_restart strobe=%b got=%h/%h exp=%h/%h", got, frame1, frame2, a1, a2);
        end
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ready1, ready2, strobe, running} !== 4'b0000 || dbg_state !== 2'd0) begin
            n_err++; $display("FAIL abort_rst_ctrl got=%b st=%0d exp=0000 st=0", {ready1, ready2, strobe, running}, dbg_state);
        end
        n_vec++;
        if ({frame1, frame2} !== '0 || {ucnt1, ucnt2} !== 16'h0000) begin
            n_err++; $display("FAIL abort_rst_data got=%h/%h cnt=%0d/%0d exp=0", frame1, frame2, ucnt1, ucnt2);
        end
        bench_u1 = 0; bench_u2 = 0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (strobe !== 1'b0 || running !== 1'b0) begin
            n_err++; $display("FAIL abort_rst_hold got=%b%b exp=00", strobe, running);
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_steady();
        test_underrun();
        test_back_to_back();
        test_saturation();
        test_abort();
        test_startup();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tdm_frame_sched.md
TDM_FRAME_SCHED -- requirements
Module: tdm_frame_sched

Interface
REQ-001 SHALL have parameter G_BITS, default 16: sample width per channel.
REQ-002 SHALL have parameter G_FRAME_MCLKS, default 66: in_mclk cycles per TDM frame; legal range 2..65535.
REQ-003 SHALL have port in_mclk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port in_rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_enable, input, 1: run request.
REQ-006 SHALL have ports in_ch1_data, in_ch2_data, input, G_BITS: requester samples.
REQ-007 SHALL have ports in_ch1_valid, in_ch2_valid, input, 1: requester sample valid.
REQ-008 SHALL have ports out_ch1_ready, out_ch2_ready, output, 1: sample accepted when valid and ready are both high at a rising edge.
REQ-009 SHALL have ports out_frame_1, out_frame_2, output, G_BITS: frame words toward the TDM transmitter.
REQ-010 SHALL have port out_frame_strobe, output, 1: one-cycle pulse; frame words valid while high.
REQ-011 SHALL have port out_running, output, 1: high in state RUN.
REQ-012 SHALL have ports out_underrun_cnt_1, out_underrun_cnt_2, output, 8: per-channel underrun counters.

Function
REQ-013 SHALL hold one 2-entry FIFO per channel; push on valid&ready; ready = not full and state != IDLE; a full FIFO SHALL NOT accept a push even if it pops in the same cycle.
REQ-014 SHALL implement states IDLE, PRIME, RUN.
REQ-015 IDLE: FIFOs held empty, readies low, frame counter 0; in_enable=1 -> PRIME next edge.
REQ-016 PRIME: FIFOs fill, no strobes; both FIFOs non-empty at an edge -> RUN with frame counter 0.
REQ-017 RUN: frame counter increments every cycle and wraps from G_FRAME_MCLKS-1 to 0.
REQ-018 RUN with counter==0: at that edge register out_frame_x <= head of FIFO x and pop it; out_frame_strobe=1 for exactly the following cycle; strobe 0 at all other times.
REQ-019 First strobe SHALL appear the cycle after PRIME->RUN; strobe period SHALL be exactly G_FRAME_MCLKS cycles thereafter.
REQ-020 Underrun: FIFO x empty at a counter==0 edge -> out_frame_x holds its previous value, no pop, out_underrun_cnt_x increments saturating at 255; the other channel unaffected.
REQ-021 Push into an empty FIFO on a counter==0 edge SHALL count as underrun; the pushed word is used at the next frame.
REQ-022 in_enable=0 in PRIME or RUN -> IDLE next edge, FIFOs flushed, any sample being pushed that cycle discarded; no strobe is issued on that edge; out_frame_x retain values.
REQ-023 Underrun counters SHALL clear only on reset, not on IDLE.
REQ-024 out_running SHALL be registered, equal to (state==RUN).

Reset
REQ-025 in_rst_n=0 SHALL asynchronously force: state IDLE, FIFOs empty, frame counter 0, out_frame_1=out_frame_2=0, out_frame_strobe=0, readies 0, out_running=0, underrun counters 0.
REQ-026 Reset asserted mid-RUN SHALL abort the frame immediately; after release the block SHALL behave as after power-up.
REQ-027 Reset release SHALL take effect on the first rising in_mclk edge after in_rst_n goes high.

Verification
REQ-028 Startup: enable=1, ch1 pushes 0x1111 at cycle 3, ch2 pushes 0x2222 at cycle 10 -> RUN entered at edge 11, strobe in the cycle after it with frames 0x1111/0x2222, no strobe earlier.
REQ-029 Steady stream, G_FRAME_MCLKS=66: both channels push one sample per frame -> strobes exactly 66 cycles apart, frame words in push order, counters stay 0.
REQ-030 Underrun: ch2 withholds one sample -> that strobe shows new ch1 word, previous ch2 word, out_underrun_cnt_2=1, cnt_1=0.
REQ-031 Backpressure: both channels push continuously -> each ready low after 2 accepted samples, re-high after each pop; no sample lost or duplicated.
REQ-032 Saturation: ch1 idle for 300 frames in RUN -> out_underrun_cnt_1 stops at 255.
REQ-033 Abort: enable=0 mid-frame, then reset pulse mid-RUN -> IDLE, readies 0, no further strobes; after reset all outputs 0 and restart reproduces REQ-028 timing.
